// File: rtl/fpu_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_wb_if
// Description : Handshake bundle between the core/FPU and the FPU writeback
//               stage. It carries the issue tag, the FPU's registered results,
//               the regfile writeback port and the interrupt pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_wb_if #(
  parameter int STD = 31
);
  // Issue side: op presented to the FPU this cycle
  logic         issue_valid;
  logic         issue_ready;
  logic [4:0]   issue_rd;
  logic         issue_dst_int;
  logic         issue_exc;

  // FPU results, valid the cycle after issue
  logic [STD:0] fpu_resultant;
  logic [31:0]  fpu_result_rd;
  logic [4:0]   fpu_s_flags;
  logic         fpu_interrupt;

  // Register-file writeback port
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_rd;
  logic         wb_is_int;
  logic [31:0]  wb_data;
  logic         wb_exc;
  logic         irq;

  // Core / FPU side
  modport master (
    output issue_valid, issue_rd, issue_dst_int, issue_exc,
    output fpu_resultant, fpu_result_rd, fpu_s_flags, fpu_interrupt,
    output wb_ready,
    input  issue_ready, wb_valid, wb_rd, wb_is_int, wb_data, wb_exc, irq
  );

  // Writeback stage side
  modport slave (
    input  issue_valid, issue_rd, issue_dst_int, issue_exc,
    input  fpu_resultant, fpu_result_rd, fpu_s_flags, fpu_interrupt,
    input  wb_ready,
    output issue_ready, wb_valid, wb_rd, wb_is_int, wb_data, wb_exc, irq
  );
endinterface
`default_nettype wire

// File: rtl/fpu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : fpu_writeback_stage
// Description : Tracks FPU ops across the FPU's one-cycle latency, buffers
//               results in a small FIFO, presents them to the regfile with a
//               valid/ready handshake and owns the fflags/frm CSR state.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_writeback_stage #(
  parameter int STD   = 31,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_l,
  fpu_wb_if.slave         bus,
  input  wire logic       flush,
  input  wire logic       csr_we,
  input  wire logic [7:0] csr_wdata,
  output logic      [4:0] fflags,
  output logic      [2:0] frm
);

  // In-flight tag: op issued last cycle whose result appears this cycle
  logic          r_inflight;
  logic [4:0]    r_tag_rd;
  logic          r_tag_int;
  logic          r_tag_exc;

  // Result FIFO storage
  logic [4:0]    r_mem_rd    [DEPTH];
  logic          r_mem_int   [DEPTH];
  logic          r_mem_exc   [DEPTH];
  logic [31:0]   r_mem_data  [DEPTH];
  logic [4:0]    r_mem_flags [DEPTH];
  logic          r_mem_irq   [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_irq;

  logic [31:0]   w_fp_data;
  logic [31:0]   w_cap_data;
  logic [AW+1:0] w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_pop_flags;

  // Narrow FP results are NaN-boxed into the 32-bit writeback word
  if (STD < 31) begin : g_nanbox
    assign w_fp_data = {{(31 - STD){1'b1}}, bus.fpu_resultant};
  end else begin : g_nobox
    assign w_fp_data = bus.fpu_resultant;
  end

  assign w_cap_data  = r_tag_int ? bus.fpu_result_rd : w_fp_data;

  // Occupancy counts the in-flight op so a full FIFO can never overflow
  assign w_occupancy = {1'b0, r_count} + {{(AW + 1){1'b0}}, r_inflight};

  assign bus.issue_ready = rst_l & ~flush & (w_occupancy < (AW + 2)'(DEPTH));
  assign w_issue         = bus.issue_valid & bus.issue_ready;
  // A result arriving in a flush cycle belongs to a discarded op
  assign w_push          = r_inflight & ~flush;
  assign w_pop           = bus.wb_valid & bus.wb_ready;

  // Writeback port driven straight from the FIFO head, zeroed when empty
  assign bus.wb_valid  = (r_count != '0);
  assign bus.wb_rd     = bus.wb_valid ? r_mem_rd[r_rd_ptr]   : 5'd0;
  assign bus.wb_is_int = bus.wb_valid & r_mem_int[r_rd_ptr];
  assign bus.wb_exc    = bus.wb_valid & r_mem_exc[r_rd_ptr];
  assign bus.wb_data   = bus.wb_valid ? r_mem_data[r_rd_ptr] : 32'd0;
  assign bus.irq       = r_irq;

  assign w_pop_flags   = w_pop ? r_mem_flags[r_rd_ptr] : 5'd0;

  // Track the op issued this cycle through the FPU's registered latency
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_inflight <= 1'b0;
      r_tag_rd   <= 5'd0;
      r_tag_int  <= 1'b0;
      r_tag_exc  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_rd  <= bus.issue_rd;
        r_tag_int <= bus.issue_dst_int;
        r_tag_exc <= bus.issue_exc;
      end
    end
  end

  // Capture the FPU result with its tag into the FIFO slot at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]    <= r_tag_rd;
      r_mem_int[r_wr_ptr]   <= r_tag_int;
      r_mem_exc[r_wr_ptr]   <= r_tag_exc;
      r_mem_data[r_wr_ptr]  <= w_cap_data;
      r_mem_flags[r_wr_ptr] <= bus.fpu_s_flags;
      r_mem_irq[r_wr_ptr]   <= bus.fpu_interrupt;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer outright
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Interrupt pulse one cycle after the flagged entry is accepted
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_irq <= 1'b0;
    else        r_irq <= w_pop & r_mem_irq[r_rd_ptr];
  end

  // CSR state: flags accrue only when a result is accepted; a CSR write in
  // the same cycle still keeps the retiring entry's flags
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fflags <= 5'd0;
      frm    <= 3'd0;
    end else if (csr_we) begin
      fflags <= csr_wdata[4:0] | w_pop_flags;
      frm    <= csr_wdata[7:5];
    end else begin
      fflags <= fflags | w_pop_flags;
    end
  end

endmodule
`default_nettype wire

// File: doc/fpu_writeback_stage.md
Name: fpu_writeback_stage

Overview:
- Sits directly downstream of the single-cycle FPU top.
- Tracks each issued FPU op through the FPU's one-cycle registered latency and captures its result and flags into a small FIFO.
- Presents results to the register-file writeback port with a valid/ready handshake.
- Owns the architectural fflags/frm CSR state: flags retire stickily only when the result is accepted.

Parameters:
- STD, 31: MSB index of the FP result (31 single, 15 half).
- DEPTH, 2: result FIFO entries (power of 2, >= 2).
- AW, 1: FIFO pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- issue_valid  in  1  an op is presented to the FPU this cycle
- issue_ready  out  1  stage can accept the result of an op issued this cycle
- issue_rd  in  5  destination register index
- issue_dst_int  in  1  1 = integer regfile (FPU_Result_rd), 0 = FP regfile (FPU_resultant)
- issue_exc  in  1  FPU asynchronous Exception_flag for this op
- fpu_resultant  in  STD+1  FPU FP result (valid the cycle after issue)
- fpu_result_rd  in  32  FPU integer result (valid the cycle after issue)
- fpu_s_flags  in  5  FPU flags {NV,DZ,OF,UF,NX} (valid the cycle after issue)
- fpu_interrupt  in  1  FPU interrupt pin (valid the cycle after issue)
- flush  in  1  discard in-flight and buffered results
- wb_valid  out  1  writeback entry available
- wb_ready  in  1  regfile accepts entry
- wb_rd  out  5  destination index
- wb_is_int  out  1  destination is integer regfile
- wb_data  out  32  writeback data
- wb_exc  out  1  entry was an exception op
- irq  out  1  pulse: accepted entry carried fpu_interrupt
- csr_we  in  1  CSR write strobe
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}
- fflags  out  5  sticky accrued flags
- frm  out  3  dynamic rounding mode to FPU

Behaviour:
- **Reset** (rst_l low, async): all outputs 0; FIFO empty; in-flight tag invalid; fflags=0; frm=0.
- **Issue, cycle 0:** when issue_valid & issue_ready, register a tag {rd, dst_int, exc} and set inflight=1.
  - issue_valid while issue_ready=0 is ignored; the core must hold the FPU op.
- **Capture, cycle 1:** if inflight, push {tag, data, s_flags, interrupt} into the FIFO. inflight clears unless a new issue occurs the same cycle. Back-to-back issues give one push per cycle.
- **Data selection at capture:**
  - dst_int=1: data = fpu_result_rd.
  - dst_int=0: data = fpu_resultant, NaN-boxed. Bits 31:STD+1 are 1s when STD<31.
- **issue_ready** = (count + inflight) < DEPTH, where count is FIFO occupancy. It is combinational from registered state only, so a full FIFO never overflows.
- **Writeback:** wb_* driven from the FIFO head; wb_valid = count!=0. An entry pops on wb_valid & wb_ready.
  - Minimum issue-to-wb_valid latency is 2 cycles.
  - Push and pop in the same cycle: count unchanged.
- **fflags accrual:** on pop, fflags <= fflags | head.flags.
  - csr_we alone: {frm, fflags} <= csr_wdata.
  - csr_we and pop in the same cycle: fflags <= csr_wdata[4:0] | head.flags; frm <= csr_wdata[7:5].
- **irq:** 1-cycle pulse, registered, the cycle after a pop whose entry had interrupt=1.
- **flush:** synchronous. Next cycle the FIFO is empty and inflight=0.
  - fflags, frm and a same-cycle pop are unaffected. Flags of a popped head still accrue.
  - Issue in the flush cycle is dropped; issue_ready is forced 0 during flush.
- **Pointers:** wrap modulo DEPTH; count is AW+1 bits.
- **Outputs:** no combinational path from wb_ready to issue_ready; issue_ready reflects pop one cycle later.

Test Plan:
- **Reset:** pulse rst_l low mid-stream with 2 entries buffered → wb_valid=0, fflags=0, frm=0 immediately, without a clock edge.
- **FP writeback:** issue rd=5, dst_int=0, STD=15, fpu_resultant=16'h3C00 at cycle 1, flags=5'b00001, wb_ready=1 → wb_valid at cycle 2, wb_data=32'hFFFF3C00, wb_rd=5; fflags=00001 at cycle 3.
- **Backpressure:** wb_ready=0, issue every cycle, DEPTH=2 → issue_ready drops after 2 accepted issues; 3rd op is not accepted. Raise wb_ready → entries drain in order, no loss or duplication.
- **CSR collision:** fflags=00100; csr_we with wdata=8'b011_00000 in the same cycle a head with flags 10000 pops → fflags=10000, frm=011.
- **Flush:** one entry buffered plus one in flight; assert flush → next cycle wb_valid=0, issue_ready=1, fflags unchanged, nothing written back.
- **Interrupt:** entry with fpu_interrupt=1 and dst_int=1 (fpu_result_rd=32'h7FC00000) popped → irq high for exactly the cycle after the pop; wb_exc reflects the issued exc.
